switch_input_queues: RTL
========================

Name: switch_input_queues

Overview:
- Input-side buffering stage that sits directly upstream of the 4x4 round-robin arbiter.
- Holds one FIFO per source and drives the arbiter's `request` vector: bit i is high while FIFO i is non-empty and the output stage can accept a word.
- Consumes the arbiter's one-hot `grant` in the same cycle, pops the granted FIFO and registers the word, with its source index, onto a single valid/ready output toward the crossbar/egress.

Parameters:
- NUM_PORTS, 4, number of sources; must match the arbiter width.
- DATA_W, 32, payload width per word.
- DEPTH, 8, words per FIFO; power of two, >= 2.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_PORTS  per-source write strobe.
- in_ready  out  NUM_PORTS  per-source FIFO not full.
- in_data  in  NUM_PORTS*DATA_W  packed payloads; source i occupies bits [i*DATA_W +: DATA_W].
- request  out  NUM_PORTS  to arbiter request.
- grant  in  NUM_PORTS  from arbiter grant, one-hot or zero, combinational from request.
- out_valid  out  1  registered output word valid.
- out_data  out  DATA_W  registered payload.
- out_src  out  $clog2(NUM_PORTS)  index of the source that supplied out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset: synchronous, active-high.
  - All FIFOs are emptied: pointers and counts go to 0.
  - out_valid=0, out_data=0, out_src=0, request=0.
  - in_ready is 1 for all ports from the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all buffered and in-flight words with no partial output.
- Push: word i is written when in_valid[i] && in_ready[i]. Ports are independent, so all 4 may push in the same cycle.
- in_ready[i] is !full[i], decoded from the registered count. There is no bypass: a full FIFO stays not-ready even when it is popped in the same cycle.
- Output stage acceptance: out_can_accept = !out_valid || out_ready.
- Request: request[i] = !empty[i] && out_can_accept.
  - Masking on out_can_accept is mandatory. The arbiter advances its pointer on any grant, so a grant with no pop would break fairness.
- Pop: pop[i] = grant[i] && request[i].
  - A grant bit on a non-requesting port is ignored.
  - A non-one-hot grant pops only the lowest-index valid bit and is reported under IQ_STATS_EN.
- Output register:
  - On a pop: out_valid<=1, out_data<=head[i], out_src<=i.
  - Otherwise, if out_ready: out_valid<=0. out_data and out_src hold their values.
- Latency: a word pushed in cycle N raises request in N+1 (if at the head and unstalled). It is popped in N+1 and appears on out_valid in N+2. Minimum latency is 2 cycles.
- Throughput: one word per cycle aggregate while out_ready stays high.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance, order preserved.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits and must never exceed DEPTH.
- Backpressure: while out_valid && !out_ready, request is all zero and FIFOs only fill. When out_ready returns, requests reappear the same cycle.

Optional Feature:
- Macro: IQ_STATS_EN.
- When defined, two extra output ports are added:
  - stat_pop_cnt (NUM_PORTS*16): per-source 16-bit saturating counters of popped words. They clear on reset and hold at 16'hFFFF.
  - stat_bad_grant (1): sticky flag, set when grant is non-one-hot or has a bit set on a non-requesting port. It clears only on reset.
- When undefined, these ports and their logic are absent, and datapath behaviour is identical.

Decomposition:
- Package switch_iq_pkg holds:
  - NUM_PORTS_DEF=4
  - port index typedef (port_idx_t, logic [1:0])
  - FIFO count typedef
  - STAT_W=16
- Sub-module: switch_iq_fifo, a single synchronous FIFO with push/pop, full/empty, count and a combinational head output. It is instantiated NUM_PORTS times in a generate loop.
- The pop mux and output register stay in the top module.

Test Plan:
- Reset, then push 0xA0 into port 2 at cycle 1 with the arbiter connected and out_ready=1 -> request=4'b0100 at cycle 2; out_valid=1, out_data=0xA0, out_src=2 at cycle 3.
- All 4 ports push one word each (0x10, 0x11, 0x12, 0x13) in the same cycle, out_ready=1 -> outputs on consecutive cycles with src order 0,1,2,3 (arbiter pointer starts at 0).
- Fill port 1 with 8 words (DEPTH=8) while out_ready=0 -> in_ready[1]=0 after the 8th push; a 9th in_valid is not written; drain returns exactly 8 words in order.
- Hold out_ready=0 with out_valid=1 and 3 ports non-empty -> request=0 and grant=0 for the entire stall; out_data stable; no FIFO count decreases.
- Assert reset for 1 cycle while ports 0 and 3 each hold 4 words -> next cycle out_valid=0, request=0, in_ready=4'b1111; no stale word ever appears on out_data.
- With IQ_STATS_EN, force grant=4'b0011 while ports 0 and 1 request -> only port 0 pops; stat_bad_grant=1 sticky; stat_pop_cnt[0] increments by 1.

Source files
------------

// File: rtl/switch_iq_pkg.sv
// Shared constants and types for the switch input-queue stage.
package switch_iq_pkg;

  localparam int unsigned NUM_PORTS_DEF = 4;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned DEPTH_DEF     = 8;
  localparam int unsigned STAT_W        = 16;
  localparam int unsigned PORT_IDX_W    = $clog2(NUM_PORTS_DEF);
  localparam int unsigned FIFO_CNT_W    = $clog2(DEPTH_DEF) + 1;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

endpackage

// File: rtl/switch_iq_fifo.sv
// Single-clock FIFO with registered count and a combinational head word.
module switch_iq_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_c_o,
  output logic              full_c_o,
  output logic              empty_c_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full_c_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_c_o = (cnt_q == '0);
  assign do_push   = push_i && !full_c_o;
  assign do_pop    = pop_i && !empty_c_o;
  assign head_c_o  = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  // Pointers wrap naturally; count only moves on an unbalanced push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/switch_input_queues.sv
// Per-source input FIFOs feeding a round-robin arbiter; the granted head is
// registered onto one valid/ready output. Optional statistics: IQ_STATS_EN.
module switch_input_queues
  import switch_iq_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned DEPTH     = DEPTH_DEF,
  localparam int unsigned SRC_W     = $clog2(NUM_PORTS),
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        request,
  input  logic [NUM_PORTS-1:0]        grant,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready
`ifdef IQ_STATS_EN
  ,
  output logic [NUM_PORTS*STAT_W-1:0] stat_pop_cnt,
  output logic                        stat_bad_grant
`endif
);

  logic [DATA_W-1:0]    head     [NUM_PORTS];
  logic [CNT_W-1:0]     fifo_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] grant_vld;
  logic [SRC_W-1:0]     pop_idx;
  logic                 any_pop;
  logic                 out_can_accept;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q,  out_data_d;
  logic [SRC_W-1:0]     out_src_q,   out_src_d;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    switch_iq_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_i    (in_valid[g] && in_ready[g]),
      .wdata_i   (in_data[g*DATA_W +: DATA_W]),
      .pop_i     (pop[g]),
      .head_c_o  (head[g]),
      .full_c_o  (full[g]),
      .empty_c_o (empty[g]),
      .count_o   (fifo_cnt[g])
    );
  end

  // Requests are withheld while the output register is stalled, so the
  // arbiter never issues a grant that does not turn into a pop.
  assign out_can_accept = !out_valid_q || out_ready;
  assign in_ready       = ~full & {NUM_PORTS{!reset}};
  assign request        = ~empty & {NUM_PORTS{out_can_accept && !reset}};

  // Honour only the lowest-index grant bit that matches a live request.
  always_comb begin
    grant_vld = grant & request;
    pop       = '0;
    pop_idx   = '0;
    any_pop   = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (grant_vld[i]) begin
        pop     = '0;
        pop[i]  = 1'b1;
        pop_idx = SRC_W'(i);
        any_pop = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (any_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = head[pop_idx];
      out_src_d   = pop_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        assert (fifo_cnt[i] <= CNT_W'(DEPTH));
      end
    end
  end

`ifdef IQ_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q [NUM_PORTS];
  logic [STAT_W-1:0] stat_cnt_d [NUM_PORTS];
  logic              bad_grant_q, bad_grant_d;

  // Saturating pop counters and a sticky flag for malformed grants.
  always_comb begin
    bad_grant_d = bad_grant_q
                  || ((grant & ~request) != '0)
                  || ((grant & (grant - NUM_PORTS'(1))) != '0);
    for (int i = 0; i < NUM_PORTS; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
      if (pop[i] && (stat_cnt_q[i] != '1)) stat_cnt_d[i] = stat_cnt_q[i] + STAT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bad_grant_q <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) stat_cnt_q[i] <= '0;
    end else begin
      bad_grant_q <= bad_grant_d;
      for (int i = 0; i < NUM_PORTS; i++) stat_cnt_q[i] <= stat_cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
    assign stat_pop_cnt[g*STAT_W +: STAT_W] = stat_cnt_q[g];
  end
  assign stat_bad_grant = bad_grant_q;
`endif

endmodule
